ball_game_ctrl: RTL

Game sequencer for the single-player ball-and-paddle design. Starts, serves, pauses and ends the game by driving the ball engine's enable and re-initialise inputs. Detects each ball arrival at the left (paddle) wall and classifies it as a hit or a miss against the current paddle position. Maintains a two-digit BCD score and a lives count for the display/HUD logic.

---
 rtl/ball_game_pkg.sv | 36 +++
 rtl/bcd_score_counter.sv | 39 +++
 rtl/ball_game_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/ball_game_pkg.sv
// ---------------------------------------------------------------------------
// ball_game_pkg
// Shared definitions for the ball-and-paddle game sequencer.
//   - state_t      : game FSM state encoding (3-bit, codes 0..4 legal)
//   - COORD_W      : screen coordinate width
//   - WALL_X_DEF   : default paddle-wall x threshold
//   - PADDLE_H_DEF : default paddle height in pixels
//   - paddle_hit() : inclusive paddle span test, evaluated one bit wider
// ---------------------------------------------------------------------------
package ball_game_pkg;

  localparam int COORD_W = 11;

  typedef logic [COORD_W-1:0] coord_t;

  localparam coord_t WALL_X_DEF   = 11'd30;
  localparam coord_t PADDLE_H_DEF = 11'd64;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_MISS  = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  // The paddle bottom is formed one bit wider than a coordinate so a paddle
  // near the bottom of the coordinate range never wraps round to the top.
  function automatic logic paddle_hit(coord_t ball_y, coord_t paddle_y,
                                      coord_t paddle_h);
    logic [COORD_W:0] bottom;
    bottom = {1'b0, paddle_y} + {1'b0, paddle_h};
    return (ball_y >= paddle_y) && ({1'b0, ball_y} <= bottom);
  endfunction

endpackage

// File: rtl/bcd_score_counter.sv
// ---------------------------------------------------------------------------
// bcd_score_counter
// Two-digit BCD score, 00..99, wrapping from 99 to 00.
//   clk  : system clock
//   rst  : asynchronous active-high reset (score 00)
//   clr  : synchronous clear to 00, takes priority over inc
//   inc  : add one to the score
//   tens : tens digit, BCD
//   ones : ones digit, BCD
// ---------------------------------------------------------------------------
module bcd_score_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  // Ones digit rolls 9->0 and carries into tens; tens rolls 9->0 and the
  // carry out of the top digit is dropped, giving the 99 -> 00 wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tens <= 4'd0;
      ones <= 4'd0;
    end else if (clr) begin
      tens <= 4'd0;
      ones <= 4'd0;
    end else if (inc) begin
      if (ones == 4'd9) begin
        ones <= 4'd0;
        tens <= (tens == 4'd9) ? 4'd0 : tens + 4'd1;
      end else begin
        ones <= ones + 4'd1;
      end
    end
  end

endmodule

// File: rtl/ball_game_ctrl.sv
// ---------------------------------------------------------------------------
// ball_game_ctrl
// Game sequencer: serves, plays, pauses after misses and ends the game,
// scoring paddle hits and counting lives.
//   clk, rst          : clock, asynchronous active-high reset
//   start             : start button level (rising edge used)
//   frame_tick        : one-cycle pulse per video frame
//   ball_x, ball_y    : ball engine position
//   paddle_y          : paddle top edge
//   ball_en           : ball engine motion enable
//   ball_clr          : one-cycle ball re-initialise pulse
//   score_tens/ones   : BCD score
//   lives             : remaining lives
//   game_over         : high while in OVER
//   state             : current FSM state code
// ---------------------------------------------------------------------------
module ball_game_ctrl
  import ball_game_pkg::*;
#(
  parameter logic [10:0] WALL_X       = WALL_X_DEF,
  parameter logic [10:0] PADDLE_H     = PADDLE_H_DEF,
  parameter logic [1:0]  LIVES        = 2'd3,
  parameter logic [7:0]  SERVE_FRAMES = 8'd60,
  parameter logic [7:0]  MISS_FRAMES  = 8'd30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        frame_tick,
  input  logic [10:0] ball_x,
  input  logic [10:0] ball_y,
  input  logic [10:0] paddle_y,
  output logic        ball_en,
  output logic        ball_clr,
  output logic [3:0]  score_tens,
  output logic [3:0]  score_ones,
  output logic [1:0]  lives,
  output logic        game_over,
  output logic [2:0]  state
);

  state_t     state_q, state_d;
  logic       start_q, at_wall_q;
  logic [7:0] frame_cnt;
  logic [1:0] lives_q, lives_d;
  logic       ball_en_q, ball_clr_q, game_over_q;
  logic       ball_en_d, ball_clr_d, game_over_d;
  logic       start_rise, at_wall, wall_evt, hit;
  logic       frame_done, new_game, score_inc, miss_evt;

  assign start_rise = start & ~start_q;
  assign at_wall    = (ball_x <= WALL_X);
  assign wall_evt   = at_wall & ~at_wall_q;
  assign hit        = paddle_hit(ball_y, paddle_y, PADDLE_H);
  assign new_game   = start_rise & ((state_q == ST_IDLE) | (state_q == ST_OVER));
  assign score_inc  = (state_q == ST_PLAY) & wall_evt & hit;
  assign miss_evt   = (state_q == ST_PLAY) & wall_evt & ~hit;

  // The tick that brings the count up to the target length is the one that
  // ends the wait, so compare against target-1 before the increment lands.
  always_comb begin
    frame_done = 1'b0;
    if (frame_tick) begin
      if (state_q == ST_SERVE)
        frame_done = (frame_cnt == SERVE_FRAMES - 8'd1);
      else if (state_q == ST_MISS)
        frame_done = (frame_cnt == MISS_FRAMES - 8'd1);
    end
  end

  // State and all outputs are registered; the frame counter restarts on
  // every state change so a tick in the entry cycle is never counted, and
  // the edge detectors sample every cycle regardless of state. Reset leaves
  // start_q/at_wall_q high so a held button or a ball parked at the wall
  // cannot fire a spurious edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      start_q     <= 1'b1;
      at_wall_q   <= 1'b1;
      frame_cnt   <= 8'd0;
      lives_q     <= LIVES;
      ball_en_q   <= 1'b0;
      ball_clr_q  <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_q     <= start;
      at_wall_q   <= at_wall;
      lives_q     <= lives_d;
      ball_en_q   <= ball_en_d;
      ball_clr_q  <= ball_clr_d;
      game_over_q <= game_over_d;
      if (state_d != state_q)
        frame_cnt <= 8'd0;
      else if (frame_tick && (state_q == ST_SERVE || state_q == ST_MISS))
        frame_cnt <= frame_cnt + 8'd1;
    end
  end

  // Next-state logic; unused codes fall back to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_rise) state_d = ST_SERVE;
      ST_SERVE: if (frame_done) state_d = ST_PLAY;
      ST_PLAY:  if (miss_evt)   state_d = ST_MISS;
      ST_MISS:  if (frame_done) state_d = (lives_q == 2'd0) ? ST_OVER : ST_SERVE;
      ST_OVER:  if (start_rise) state_d = ST_SERVE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output values for the coming cycle, derived from the state being
  // entered; ball_clr fires only on the edge that moves into SERVE.
  always_comb begin
    ball_en_d   = (state_d == ST_PLAY);
    game_over_d = (state_d == ST_OVER);
    ball_clr_d  = (state_d == ST_SERVE) && (state_q != ST_SERVE);
    lives_d     = lives_q;
    if (new_game)
      lives_d = LIVES;
    else if (miss_evt)
      lives_d = lives_q - 2'd1;
  end

  bcd_score_counter u_score (
    .clk  (clk),
    .rst  (rst),
    .clr  (new_game),
    .inc  (score_inc),
    .tens (score_tens),
    .ones (score_ones)
  );

  assign ball_en   = ball_en_q;
  assign ball_clr  = ball_clr_q;
  assign lives     = lives_q;
  assign game_over = game_over_q;
  assign state     = state_q;

endmodule
